// File: rtl/pe_config_loader.sv
// pe_config_loader: clears a PE config chain, then streams CHAIN_LEN bits into it, LSB of each word first
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 begin a load (sampled only in IDLE)
//   word_in/word_valid    configuration word stream, word_ready accepts it
//   cfg_bit/cfg_shift     serial bit and shift strobe towards the chain
//   cfg_reset             chain clear request
//   busy/done             load in progress / one-cycle completion pulse
//   crc_err               trailer CRC mismatch (only with CFG_LOADER_CRC_EN, otherwise 0)
// Optional feature macro: CFG_LOADER_CRC_EN
module pe_config_loader #(
   parameter int WORD_W     = 32,
   parameter int CHAIN_LEN  = 12,
   parameter int CLR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_bit,
   output logic              cfg_shift,
   output logic              cfg_reset,
   output logic              busy,
   output logic              done,
   output logic              crc_err
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WORD_W + 1);
   localparam int KW = $clog2(CLR_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, CHECK, DONE} state_t;
   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [KW-1:0]     clr_q, clr_d;
`ifdef CFG_LOADER_CRC_EN
   logic [7:0]        crc_q, crc_d;
   logic              err_q, err_d;
`endif
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      clr_d   = clr_q;
`ifdef CFG_LOADER_CRC_EN
      crc_d   = crc_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = CLEAR;
            clr_d   = '0;
            cnt_d   = '0;
`ifdef CFG_LOADER_CRC_EN
            crc_d   = '0;
            err_d   = 1'b0;
`endif
         end
         CLEAR: begin
            cnt_d   = '0;
            clr_d   = clr_q + KW'(1);
            state_d = (clr_q == KW'(CLR_CYCLES - 1)) ? LOAD : CLEAR;
         end
         LOAD: if (word_valid) begin
            sreg_d  = word_in;
            wcnt_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            wcnt_d = wcnt_q + CW'(0) + WW'(1);
`ifdef CFG_LOADER_CRC_EN
            // serial CRC-8, poly x^8+x^2+x+1, register MSB is the feedback tap
            crc_d  = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sreg_q[0]) ? 8'h07 : 8'h00);
`endif
            // chain length wins over word boundary so surplus word bits are dropped
            if (cnt_q == CW'(CHAIN_LEN - 1))
`ifdef CFG_LOADER_CRC_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            else if (wcnt_q == WW'(WORD_W - 1))
               state_d = LOAD;
         end
`ifdef CFG_LOADER_CRC_EN
         CHECK: if (word_valid) begin
            err_d   = word_in[7:0] != crc_q;
            state_d = DONE;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         clr_q   <= '0;
`ifdef CFG_LOADER_CRC_EN
         crc_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         clr_q   <= clr_d;
`ifdef CFG_LOADER_CRC_EN
         crc_q   <= crc_d;
         err_q   <= err_d;
`endif
      end
   end
   assign word_ready = state_q == LOAD || state_q == CHECK;
   assign cfg_shift  = state_q == SHIFT;
   assign cfg_bit    = cfg_shift & sreg_q[0];
   assign cfg_reset  = state_q == CLEAR;
   assign busy       = state_q == CLEAR || state_q == LOAD || state_q == SHIFT || state_q == CHECK;
   assign done       = state_q == DONE;
`ifdef CFG_LOADER_CRC_EN
   assign crc_err    = err_q;
`else
   assign crc_err    = 1'b0;
`endif
endmodule

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader: directed checks of pe_config_loader with 12-bit and 40-bit chains
module tb_pe_config_loader;
`ifdef CFG_LOADER_CRC_EN
   localparam int CRC = 1;
`else
   localparam int CRC = 0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        a_word_ready, a_cfg_bit, a_cfg_shift, a_cfg_reset, a_busy, a_done, a_crc_err;
   logic        b_word_ready, b_cfg_bit, b_cfg_shift, b_cfg_reset, b_busy, b_done, b_crc_err;
   int          vecs = 0;
   int          errs = 0;
   always #5 clk = ~clk;
   pe_config_loader #(.WORD_W(32), .CHAIN_LEN(12), .CLR_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .word_in(word_in), .word_valid(word_valid),
      .word_ready(a_word_ready), .cfg_bit(a_cfg_bit), .cfg_shift(a_cfg_shift),
      .cfg_reset(a_cfg_reset), .busy(a_busy), .done(a_done), .crc_err(a_crc_err));
   pe_config_loader #(.WORD_W(32), .CHAIN_LEN(40), .CLR_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .word_in(word_in), .word_valid(word_valid),
      .word_ready(b_word_ready), .cfg_bit(b_cfg_bit), .cfg_shift(b_cfg_shift),
      .cfg_reset(b_cfg_reset), .busy(b_busy), .done(b_done), .crc_err(b_crc_err));
   task automatic test_reset();
      logic [6:0] oa, ob;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      oa = {a_word_ready, a_cfg_bit, a_cfg_shift, a_cfg_reset, a_busy, a_done, a_crc_err};
      ob = {b_word_ready, b_cfg_bit, b_cfg_shift, b_cfg_reset, b_busy, b_done, b_crc_err};
      vecs++;
      if (oa !== 7'b0) begin errs++; $display("FAIL reset_a outputs=%b expected=0000000", oa); end
      vecs++;
      if (ob !== 7'b0) begin errs++; $display("FAIL reset_b outputs=%b expected=0000000", ob); end
      reset = 1'b0;
   endtask
   task automatic test_single_word();
      logic [11:0] pat = 12'hA5C;
      logic [5:0]  o, e;
      @(negedge clk);
      start_a = 1'b1; word_valid = 1'b1; word_in = 32'h0000_0A5C;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         e[5] = c >= 1 && c <= 2;
         e[4] = c == 3 || (CRC == 1 && c == 16);
         e[3] = c >= 4 && c <= 15;
         e[2] = (c >= 4 && c <= 15) ? pat[c-4] : 1'b0;
         e[1] = c >= 1 && c <= 15 + CRC;
         e[0] = c == 16 + CRC;
         o = {a_cfg_reset, a_word_ready, a_cfg_shift, a_cfg_bit, a_busy, a_done};
         vecs++;
         if (o !== e) begin
            errs++;
            $display("FAIL single_word cycle %0d {rst,rdy,shift,bit,busy,done}=%b expected=%b", c, o, e);
         end
      end
      word_valid = 1'b0;
`ifndef CFG_LOADER_CRC_EN
      vecs++;
      if (a_crc_err !== 1'b0) begin errs++; $display("FAIL crc_err_tied actual=%b expected=0", a_crc_err); end
`endif
   endtask
   task automatic test_multi_word();
      logic [31:0] w0 = 32'hC3A5_0F96;
      logic [31:0] w1 = 32'hFFFF_FF5A;
      logic        e;
      int          nw = 0, k = 0, dn = 0, s31 = 0, s32 = 0;
      @(negedge clk);
      start_b = 1'b1; word_valid = 1'b1; word_in = w0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         @(negedge clk);
         start_b = 1'b0;
         word_in = (nw == 0) ? w0 : w1;
         if (b_word_ready) nw++;
         if (b_cfg_shift) begin
            e = (k < 32) ? w0[k] : (k < 40) ? w1[k-32] : 1'bx;
            vecs++;
            if (b_cfg_bit !== e) begin errs++; $display("FAIL multi_word bit %0d actual=%b expected=%b", k, b_cfg_bit, e); end
            if (k == 31) s31 = cyc;
            if (k == 32) s32 = cyc;
            k++;
         end
         if (b_done) dn++;
      end
      word_valid = 1'b0;
      vecs++;
      if (k != 40) begin errs++; $display("FAIL multi_word shifts actual=%0d expected=40", k); end
      vecs++;
      if (s32 - s31 != 2) begin errs++; $display("FAIL multi_word gap actual=%0d expected=2", s32 - s31); end
      vecs++;
      if (nw != 2 + CRC) begin errs++; $display("FAIL multi_word accepts actual=%0d expected=%0d", nw, 2 + CRC); end
      vecs++;
      if (dn != 1) begin errs++; $display("FAIL multi_word done_count actual=%0d expected=1", dn); end
   endtask
   task automatic test_stall();
      logic [2:0] o;
      logic [1:0] s;
      int         dn = 0;
      @(negedge clk);
      start_a = 1'b1; word_valid = 1'b0; word_in = 32'h0000_0A5D;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (c >= 3) begin
            o = {a_word_ready, a_cfg_shift, a_busy};
            vecs++;
            if (o !== 3'b101) begin errs++; $display("FAIL stall cycle %0d {rdy,shift,busy}=%b expected=101", c, o); end
         end
      end
      word_valid = 1'b1;
      @(negedge clk);
      s = {a_cfg_shift, a_cfg_bit};
      vecs++;
      if (s !== 2'b11) begin errs++; $display("FAIL stall_resume {shift,bit}=%b expected=11", s); end
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (a_done) dn++;
      end
      word_valid = 1'b0;
      vecs++;
      if (dn != 1) begin errs++; $display("FAIL stall done_count actual=%0d expected=1", dn); end
   endtask
   task automatic test_reset_mid_load();
      logic [6:0] o;
      logic [1:0] p;
      int         dn = 0;
      @(negedge clk);
      start_a = 1'b1; word_valid = 1'b1; word_in = 32'h0000_0FFF;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      vecs++;
      if (a_cfg_shift !== 1'b1) begin errs++; $display("FAIL mid_reset sixth_shift actual=%b expected=1", a_cfg_shift); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      o = {a_word_ready, a_cfg_bit, a_cfg_shift, a_cfg_reset, a_busy, a_done, a_crc_err};
      vecs++;
      if (o !== 7'b0) begin errs++; $display("FAIL mid_reset outputs=%b expected=0000000", o); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         p = {a_busy, a_done};
         vecs++;
         if (p !== 2'b00) begin errs++; $display("FAIL mid_reset idle {busy,done}=%b expected=00", p); end
      end
      start_a = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         p = {a_cfg_reset, a_word_ready};
         vecs++;
         if (p !== ((c < 3) ? 2'b10 : 2'b01)) begin
            errs++;
            $display("FAIL mid_reset replay cycle %0d {rst,rdy}=%b expected=%b", c, p, (c < 3) ? 2'b10 : 2'b01);
         end
      end
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (a_done) dn++;
      end
      word_valid = 1'b0;
      vecs++;
      if (dn != 1) begin errs++; $display("FAIL mid_reset done_count actual=%0d expected=1", dn); end
   endtask
   task automatic test_start_while_busy();
      int dn = 0;
      @(negedge clk);
      start_a = 1'b1; word_valid = 1'b1; word_in = 32'h0000_0333;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (a_done) dn++;
         start_a = (c == 2 || c == 5 || c == 10 || c == 16);
      end
      start_a = 1'b0; word_valid = 1'b0;
      vecs++;
      if (dn != 1) begin errs++; $display("FAIL busy_start done_count actual=%0d expected=1", dn); end
      vecs++;
      if (a_busy !== 1'b0) begin errs++; $display("FAIL busy_start final_busy actual=%b expected=0", a_busy); end
   endtask
`ifdef CFG_LOADER_CRC_EN
   task automatic test_crc(input logic [7:0] tr, input logic e_err);
      logic [2:0] o;
      @(negedge clk);
      start_a = 1'b1; word_valid = 1'b1; word_in = 32'h0000_0A5C;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (c == 1) begin
            vecs++;
            if (a_crc_err !== 1'b0) begin errs++; $display("FAIL crc cleared_on_start actual=%b expected=0", a_crc_err); end
         end
         if (c == 4) word_in = {24'h0, tr};
         if (c == 16) begin
            o = {a_word_ready, a_busy, a_cfg_shift};
            vecs++;
            if (o !== 3'b110) begin errs++; $display("FAIL crc check_state {rdy,busy,shift}=%b expected=110", o); end
         end
         if (c == 17) begin
            o = {a_done, a_crc_err, a_busy};
            vecs++;
            if (o !== {1'b1, e_err, 1'b0}) begin
               errs++;
               $display("FAIL crc trailer %h {done,err,busy}=%b expected=%b", tr, o, {1'b1, e_err, 1'b0});
            end
         end
      end
      word_valid = 1'b0;
      repeat (5) @(negedge clk);
      vecs++;
      if (a_crc_err !== e_err) begin errs++; $display("FAIL crc held actual=%b expected=%b", a_crc_err, e_err); end
   endtask
`endif
   initial begin
      test_reset();
      test_single_word();
      test_multi_word();
      test_stall();
      test_reset_mid_load();
      test_start_while_busy();
`ifdef CFG_LOADER_CRC_EN
      test_crc(8'h4C, 1'b1);
      test_crc(8'h4D, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
